// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the reusable valid/ready pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Default IF/ID bubble payload: pc 0 in the upper half, a NOP instruction below
  localparam logic [63:0] IFID_FLUSH_DATA = {32'h0000_0000, RV_NOP};

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter, cleared only by the synchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (i_inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional 2-entry skid buffer, flush-to-bubble
// and saturating stall/flush performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(IFID_FLUSH_DATA),
  parameter bit                SKID_EN    = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  logic inFire;
  logic outFire;

  assign inFire  = i_vld & o_rdy;
  assign outFire = o_vld & i_rdy;

  if (SKID_EN) begin : gSkid
    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state_q    <= EMPTY;
        mainData_q <= '0;
        skidData_q <= '0;
      end else begin
        state_q    <= state_d;
        mainData_q <= mainData_d;
        skidData_q <= skidData_d;
      end
    end

    // A flush wins over any handshake; a beat offered in that cycle is discarded
    always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
      if (i_flush) begin
        state_d    = EMPTY;
        mainData_d = FLUSH_DATA;
      end else begin
        case (state_q)
          EMPTY: begin
            if (inFire) begin
              state_d    = ONE;
              mainData_d = i_data;
            end
          end
          ONE: begin
            if (inFire && outFire) begin
              mainData_d = i_data;
            end else if (inFire) begin
              state_d    = TWO;
              skidData_d = i_data;
            end else if (outFire) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (outFire) begin
              state_d    = ONE;
              mainData_d = skidData_q;
            end
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
      end
    end

    assign o_vld  = (state_q != EMPTY);
    assign o_rdy  = (state_q != TWO);
    assign o_data = mainData_q;
  end else begin : gSingle
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        vld_q      <= 1'b0;
        mainData_q <= '0;
      end else begin
        vld_q      <= vld_d;
        mainData_q <= mainData_d;
      end
    end

    always_comb begin
      vld_d      = vld_q;
      mainData_d = mainData_q;
      if (i_flush) begin
        vld_d      = 1'b0;
        mainData_d = FLUSH_DATA;
      end else if (inFire) begin
        vld_d      = 1'b1;
        mainData_d = i_data;
      end else if (outFire) begin
        vld_d = 1'b0;
      end
    end

    assign o_vld  = vld_q;
    assign o_rdy  = ~vld_q | i_rdy;
    assign o_data = mainData_q;
  end

  // With the skid enabled the skid entry is only valid in TWO, so o_vld covers it
  sat_counter #(.W(CNT_W)) uStallCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (o_vld & ~i_rdy),
    .o_cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (i_flush & o_vld),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance and a single-register instance, both
// with 4-bit counters, checked by a vector table and a queue-based scoreboard.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam logic [DW-1:0] FLUSH_VAL = 64'h0000_0000_0000_0013;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          flush [2];
  logic          vld   [2];
  logic          rdy   [2];
  logic [DW-1:0] din   [2];
  logic [DW-1:0] dout  [2];
  logic          ovld  [2];
  logic          ordy  [2];
  logic [CW-1:0] stallCnt [2];
  logic [CW-1:0] flushCnt [2];

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_DATA(FLUSH_VAL), .SKID_EN(1), .CNT_W(CW)) dutSkid (
    .i_clk(clk), .i_reset(rst[0]), .i_flush(flush[0]), .i_vld(vld[0]), .o_rdy(ordy[0]),
    .i_data(din[0]), .o_vld(ovld[0]), .i_rdy(rdy[0]), .o_data(dout[0]),
    .o_stall_cnt(stallCnt[0]), .o_flush_cnt(flushCnt[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_DATA(FLUSH_VAL), .SKID_EN(0), .CNT_W(CW)) dutSingle (
    .i_clk(clk), .i_reset(rst[1]), .i_flush(flush[1]), .i_vld(vld[1]), .o_rdy(ordy[1]),
    .i_data(din[1]), .o_vld(ovld[1]), .i_rdy(rdy[1]), .o_data(dout[1]),
    .o_stall_cnt(stallCnt[1]), .o_flush_cnt(flushCnt[1])
  );

  typedef struct {
    bit            rst;
    bit            flush;
    bit            vld;
    logic [DW-1:0] data;
    bit            rdy;
    bit            chk;
    bit            expVld;
    bit            expRdy;
    logic [DW-1:0] expData;
    int            expStall;
    int            expFlush;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  int            stallExp[2];
  int            testsRun = 0;
  int            testsFailed = 0;

  function automatic vec_t mkVec(bit r, bit f, bit v, logic [DW-1:0] d, bit rd, bit c,
                                 bit ev, bit er, logic [DW-1:0] ed, int es, int ef);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.data = d; t.rdy = rd; t.chk = c;
    t.expVld = ev; t.expRdy = er; t.expData = ed; t.expStall = es; t.expFlush = ef;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input bit r, input bit f, input bit v,
                               input logic [DW-1:0] d, input bit rd);
    rst[sel]   = r;
    flush[sel] = f;
    vld[sel]   = v;
    din[sel]   = d;
    rdy[sel]   = rd;
    #1;
  endtask

  // One scoreboarded cycle with no reset/flush; reports whether the beat was accepted
  task automatic sbCycle(input int sel, input bit v, input logic [DW-1:0] d, input bit rd,
                         output bit fired);
    bit expVld, expRdy, outFire;
    string tag;
    tag = (sel == 0) ? "skid" : "single";
    applyStimulus(sel, 1'b0, 1'b0, v, d, rd);
    expVld = (sb.size() != 0);
    expRdy = (sel == 0) ? (sb.size() < 2) : ((sb.size() == 0) || rd);
    checkOutput({tag, " o_vld"}, DW'(ovld[sel]), DW'(expVld));
    checkOutput({tag, " o_rdy"}, DW'(ordy[sel]), DW'(expRdy));
    if (expVld) checkOutput({tag, " o_data"}, dout[sel], sb[0]);
    checkOutput({tag, " o_stall_cnt"}, DW'(stallCnt[sel]), DW'(stallExp[sel]));
    fired   = v && expRdy;
    outFire = expVld && rd;
    if (expVld && !rd && stallExp[sel] < CNT_MAX) stallExp[sel]++;
    if (outFire) void'(sb.pop_front());
    if (fired) sb.push_back(d);
    @(negedge clk);
  endtask

  task automatic drain(input int sel);
    bit fired;
    for (int i = 0; i < 8 && sb.size() != 0; i++) sbCycle(sel, 1'b0, '0, 1'b1, fired);
    checkOutput((sel == 0) ? "skid drain leftover" : "single drain leftover", DW'(sb.size()), '0);
  endtask

  initial begin
    bit fired;
    int idx;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; flush[s] = 1'b0; vld[s] = 1'b0; rdy[s] = 1'b0; din[s] = '0;
      stallExp[s] = 0;
    end

    vecs.push_back(mkVec(1,0,1,64'hAAAA,0, 0, 0,0,64'h0,0,0));
    vecs.push_back(mkVec(1,0,1,64'hAAAA,0, 1, 0,1,64'h0,0,0));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 0,1,64'h0,0,0));
    vecs.push_back(mkVec(0,0,1,64'h11,0,   1, 0,1,64'h0,0,0));
    vecs.push_back(mkVec(0,0,1,64'h22,0,   1, 1,1,64'h11,0,0));
    vecs.push_back(mkVec(0,0,0,64'h0,0,    1, 1,0,64'h11,1,0));
    vecs.push_back(mkVec(0,0,0,64'h0,0,    1, 1,0,64'h11,2,0));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 1,0,64'h11,3,0));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 1,1,64'h22,3,0));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 0,1,64'h22,3,0));
    vecs.push_back(mkVec(0,0,1,64'hAA,0,   1, 0,1,64'h22,3,0));
    vecs.push_back(mkVec(0,0,1,64'hBB,0,   1, 1,1,64'hAA,3,0));
    vecs.push_back(mkVec(0,1,1,64'h33,0,   1, 1,0,64'hAA,4,0));
    vecs.push_back(mkVec(0,0,0,64'h0,0,    1, 0,1,FLUSH_VAL,5,1));
    vecs.push_back(mkVec(0,1,1,64'h44,1,   1, 0,1,FLUSH_VAL,5,1));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 0,1,FLUSH_VAL,5,1));
    vecs.push_back(mkVec(0,0,1,64'h55,0,   1, 0,1,FLUSH_VAL,5,1));
    vecs.push_back(mkVec(0,0,0,64'h0,0,    1, 1,1,64'h55,5,1));
    vecs.push_back(mkVec(1,0,1,64'h66,1,   1, 1,1,64'h55,6,1));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 0,1,64'h0,0,0));
    vecs.push_back(mkVec(0,0,0,64'h0,1,    1, 0,1,64'h0,0,0));

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].data, vecs[i].rdy);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d o_vld", i), DW'(ovld[0]), DW'(vecs[i].expVld));
        checkOutput($sformatf("vec%0d o_rdy", i), DW'(ordy[0]), DW'(vecs[i].expRdy));
        checkOutput($sformatf("vec%0d o_data", i), dout[0], vecs[i].expData);
        checkOutput($sformatf("vec%0d stall", i), DW'(stallCnt[0]), DW'(vecs[i].expStall));
        checkOutput($sformatf("vec%0d flush", i), DW'(flushCnt[0]), DW'(vecs[i].expFlush));
      end
      @(negedge clk);
    end

    // Back-to-back stream through the skid stage
    for (int i = 0; i < 10; i++) sbCycle(0, 1'b1, DW'(i), 1'b1, fired);
    drain(0);

    // Stall counter must stick at its maximum
    sbCycle(0, 1'b1, 64'h77, 1'b0, fired);
    for (int i = 0; i < 20; i++) sbCycle(0, 1'b0, '0, 1'b0, fired);
    checkOutput("skid stall saturated", DW'(stallCnt[0]), DW'(CNT_MAX));
    drain(0);

    for (int i = 0; i < 150; i++)
      sbCycle(0, 1'($urandom_range(0, 1)), 64'h1000 + DW'(i), 1'($urandom_range(0, 1)), fired);
    drain(0);

    // Single-register stage out of reset
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("single reset o_vld", DW'(ovld[1]), '0);
    checkOutput("single reset o_rdy", DW'(ordy[1]), 64'h1);
    checkOutput("single reset o_data", dout[1], '0);
    checkOutput("single reset stall", DW'(stallCnt[1]), '0);
    checkOutput("single reset flush", DW'(flushCnt[1]), '0);
    @(negedge clk);

    idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      sbCycle(1, 1'b1, DW'(idx), (c % 2) == 0, fired);
      if (fired) idx++;
    end
    checkOutput("single stream beats accepted", DW'(idx), 64'd10);
    drain(1);

    for (int i = 0; i < 120; i++)
      sbCycle(1, 1'($urandom_range(0, 1)), 64'h2000 + DW'(i), 1'($urandom_range(0, 1)), fired);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
